// File: rtl/pixel_compositor.sv
// Final video stage: picks the highest-priority opaque sprite layer or the background,
// blanks outside active video, realigns syncs with the pixel path, and generates a frame blink gate.
module pixel_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int SPRITE_LAT   = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    video_on,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic [NUM_LAYERS-1:0]   layer_data,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [7:0]              bg_rgb,
  input  logic [NUM_LAYERS-1:0]   blink_mask,
  output logic [2:0]              red,
  output logic [2:0]              green,
  output logic [1:0]              blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    blink_phase
);

  localparam logic [5:0] FRAME_LAST = 6'(BLINK_FRAMES - 1);

  logic [SPRITE_LAT-1:0] hs_pipe;
  logic [SPRITE_LAT-1:0] vs_pipe;
  logic [SPRITE_LAT-1:0] von_pipe;
  logic                  hs_del;
  logic                  vs_del;
  logic                  von_del;
  logic                  vs_prev_reg;
  logic                  vs_fall;
  logic [5:0]            frame_cnt_reg;
  logic [NUM_LAYERS-1:0] qual;
  logic [7:0]            sel_rgb;
  logic [7:0]            rgb_reg;

  // Syncs and video_on are delayed to land in the same cycle as the renderer outputs.
  generate
    for (genvar gi = 0; gi < SPRITE_LAT; gi++) begin : g_delay
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          hs_pipe[gi]  <= 1'b1;
          vs_pipe[gi]  <= 1'b1;
          von_pipe[gi] <= 1'b0;
        end else if (gi == 0) begin
          hs_pipe[gi]  <= hsync_in;
          vs_pipe[gi]  <= vsync_in;
          von_pipe[gi] <= video_on;
        end else begin
          hs_pipe[gi]  <= hs_pipe[(gi > 0) ? gi - 1 : 0];
          vs_pipe[gi]  <= vs_pipe[(gi > 0) ? gi - 1 : 0];
          von_pipe[gi] <= von_pipe[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign hs_del  = hs_pipe[SPRITE_LAT-1];
  assign vs_del  = vs_pipe[SPRITE_LAT-1];
  assign von_del = von_pipe[SPRITE_LAT-1];

  // A disabled renderer may hold stale data, so enable gates the opaque flag.
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_qual
      assign qual[gi] = layer_en[gi] & layer_data[gi] & ~(blink_mask[gi] & ~blink_phase);
    end
  endgenerate

  // Scan from lowest priority upward so the lowest qualified index overrides.
  always_comb begin
    sel_rgb = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (qual[i]) sel_rgb = layer_rgb[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rgb_reg <= 8'h00;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      rgb_reg <= von_del ? sel_rgb : 8'h00;
      hsync   <= hs_del;
      vsync   <= vs_del;
    end
  end

  assign red   = rgb_reg[7:5];
  assign green = rgb_reg[4:2];
  assign blue  = rgb_reg[1:0];

  assign vs_fall = vs_prev_reg & ~vs_del;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vs_prev_reg   <= 1'b1;
      frame_cnt_reg <= 6'd0;
      blink_phase   <= 1'b1;
    end else begin
      vs_prev_reg <= vs_del;
      if (vs_fall) begin
        if (frame_cnt_reg >= FRAME_LAST) begin
          frame_cnt_reg <= 6'd0;
          blink_phase   <= ~blink_phase;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor (SPRITE_LAT=1, BLINK_FRAMES=2).
module tb_pixel_compositor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        hsync_in, vsync_in, video_on;
  logic [3:0]  layer_en, layer_data, blink_mask;
  logic [31:0] layer_rgb;
  logic [7:0]  bg_rgb;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        hsync, vsync, blink_phase;
  logic [7:0]  rgb;

  int compared   = 0;
  int mismatched = 0;

  assign rgb = {red, green, blue};

  pixel_compositor #(.NUM_LAYERS(4), .SPRITE_LAT(1), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on(video_on), .layer_en(layer_en), .layer_data(layer_data),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .blink_mask(blink_mask),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .blink_phase(blink_phase)
  );

  always #20 clock = ~clock;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); video_on = 1'($urandom);
      layer_en = 4'($urandom); layer_data = 4'($urandom); blink_mask = 4'($urandom);
      layer_rgb = $urandom; bg_rgb = 8'($urandom);
      step();
    end
    compared++; if (rgb !== 8'h00) begin mismatched++; $display("FAIL reset_rgb got %h want 00", rgb); end
    compared++; if (hsync !== 1'b1) begin mismatched++; $display("FAIL reset_hsync got %b want 1", hsync); end
    compared++; if (vsync !== 1'b1) begin mismatched++; $display("FAIL reset_vsync got %b want 1", vsync); end
    compared++; if (blink_phase !== 1'b1) begin mismatched++; $display("FAIL reset_phase got %b want 1", blink_phase); end
    $display("reset: rgb=%h hsync=%b vsync=%b phase=%b", rgb, hsync, vsync, blink_phase);
  endtask

  task automatic test_priority();
    hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b1; blink_mask = 4'b0000;
    layer_en = 4'b1111; layer_data = 4'b0110;
    layer_rgb = {8'hAA, 8'h1C, 8'hE0, 8'hFF}; bg_rgb = 8'h03;
    reset_n = 1'b1;
    step(3);
    compared++; if (rgb !== 8'hE0) begin mismatched++; $display("FAIL prio_0110 got %h want e0", rgb); end
    $display("priority data=0110 rgb=%h", rgb);
    layer_data = 4'b0000; step();
    compared++; if (rgb !== 8'h03) begin mismatched++; $display("FAIL prio_bg got %h want 03", rgb); end
    $display("priority data=0000 rgb=%h", rgb);
    layer_data = 4'b1000; step();
    compared++; if (rgb !== 8'hAA) begin mismatched++; $display("FAIL prio_1000 got %h want aa", rgb); end
    $display("priority data=1000 rgb=%h", rgb);
    layer_data = 4'b1100; step();
    compared++; if (rgb !== 8'h1C) begin mismatched++; $display("FAIL prio_1100 got %h want 1c", rgb); end
    $display("priority data=1100 rgb=%h", rgb);
  endtask

  task automatic test_stale_mask();
    layer_en = 4'b1110; layer_data = 4'b0001; step();
    compared++; if (rgb !== 8'h03) begin mismatched++; $display("FAIL stale_masked got %h want 03", rgb); end
    $display("stale en=1110 data=0001 rgb=%h", rgb);
    layer_en = 4'b0001; step();
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL stale_enabled got %h want ff", rgb); end
    $display("stale en=0001 data=0001 rgb=%h", rgb);
  endtask

  task automatic test_blanking();
    layer_en = 4'b1111; layer_data = 4'b0001; video_on = 1'b0;
    step();
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL blank_delay got %h want ff", rgb); end
    step();
    compared++; if (rgb !== 8'h00) begin mismatched++; $display("FAIL blank_off got %h want 00", rgb); end
    $display("blanking video_on=0 rgb=%h", rgb);
    video_on = 1'b1; hsync_in = 1'b0;
    step();
    compared++; if (hsync !== 1'b1) begin mismatched++; $display("FAIL hsync_lat1 got %b want 1", hsync); end
    hsync_in = 1'b1;
    step();
    compared++; if (hsync !== 1'b0) begin mismatched++; $display("FAIL hsync_lat2 got %b want 0", hsync); end
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL blank_on got %h want ff", rgb); end
    step();
    compared++; if (hsync !== 1'b1) begin mismatched++; $display("FAIL hsync_end got %b want 1", hsync); end
    $display("blanking hsync pulse checked, rgb=%h", rgb);
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001; layer_en = 4'b1111; layer_data = 4'b0011;
    vsync_pulse();
    compared++; if (blink_phase !== 1'b1) begin mismatched++; $display("FAIL blink_fall1 got %b want 1", blink_phase); end
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL blink_vis1 got %h want ff", rgb); end
    $display("blink fall1 phase=%b rgb=%h", blink_phase, rgb);
    vsync_pulse();
    compared++; if (blink_phase !== 1'b0) begin mismatched++; $display("FAIL blink_fall2 got %b want 0", blink_phase); end
    compared++; if (rgb !== 8'hE0) begin mismatched++; $display("FAIL blink_hidden got %h want e0", rgb); end
    $display("blink fall2 phase=%b rgb=%h", blink_phase, rgb);
    layer_data = 4'b0001; step();
    compared++; if (rgb !== 8'h03) begin mismatched++; $display("FAIL blink_bg got %h want 03", rgb); end
    blink_mask = 4'b0000; step();
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL blink_unmasked got %h want ff", rgb); end
    blink_mask = 4'b0001; layer_data = 4'b0011;
    vsync_pulse();
    compared++; if (blink_phase !== 1'b0) begin mismatched++; $display("FAIL blink_fall3 got %b want 0", blink_phase); end
    vsync_pulse();
    compared++; if (blink_phase !== 1'b1) begin mismatched++; $display("FAIL blink_fall4 got %b want 1", blink_phase); end
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL blink_back got %h want ff", rgb); end
    $display("blink fall4 phase=%b rgb=%h", blink_phase, rgb);
  endtask

  task automatic test_reset_midframe();
    vsync_pulse(); vsync_pulse(); vsync_pulse();
    compared++; if (blink_phase !== 1'b0) begin mismatched++; $display("FAIL mid_pre got %b want 0", blink_phase); end
    hsync_in = 1'b0; vsync_in = 1'b0;
    reset_n = 1'b0; step();
    compared++; if (blink_phase !== 1'b1) begin mismatched++; $display("FAIL mid_phase got %b want 1", blink_phase); end
    compared++; if ({hsync, vsync, rgb} !== {2'b11, 8'h00}) begin
      mismatched++; $display("FAIL mid_outs got %b%b/%h want 11/00", hsync, vsync, rgb);
    end
    reset_n = 1'b1; step();
    compared++; if ({hsync, vsync, rgb} !== {2'b11, 8'h00}) begin
      mismatched++; $display("FAIL mid_refill got %b%b/%h want 11/00", hsync, vsync, rgb);
    end
    step();
    compared++; if ({hsync, vsync} !== 2'b00) begin mismatched++; $display("FAIL mid_sync got %b%b want 00", hsync, vsync); end
    compared++; if (rgb !== 8'hFF) begin mismatched++; $display("FAIL mid_rgb got %h want ff", rgb); end
    hsync_in = 1'b1; vsync_in = 1'b1; step(3);
    // Counter was cleared, so one fall must not toggle the phase.
    compared++; if (blink_phase !== 1'b1) begin mismatched++; $display("FAIL mid_cnt1 got %b want 1", blink_phase); end
    vsync_pulse();
    compared++; if (blink_phase !== 1'b0) begin mismatched++; $display("FAIL mid_cnt2 got %b want 0", blink_phase); end
    $display("reset mid-frame: phase=%b", blink_phase);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stale_mask();
    test_blanking();
    test_blink();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
